// File: rtl/m68k_bus_target_if.sv
// 68000 asynchronous bus as seen at the target's pins.
// The master side drives strobes, address, function code and write data.
// The slave side drives read data and the open-drain enable controls.
interface m68k_bus_target_if;
    logic        CLK_7M;
    logic        nAS_IN;
    logic        nUDS_IN;
    logic        nLDS_IN;
    logic        RnW_IN;
    logic [22:0] A_IN;
    logic [2:0]  FC_IN;
    logic [15:0] D_IN;
    logic [15:0] D_OUT;
    logic        D_OE;
    logic        nDTACK_OE;
    logic        nBERR_OE;

    modport master (
        output CLK_7M, nAS_IN, nUDS_IN, nLDS_IN, RnW_IN, A_IN, FC_IN, D_IN,
        input  D_OUT, D_OE, nDTACK_OE, nBERR_OE
    );

    modport slave (
        input  CLK_7M, nAS_IN, nUDS_IN, nLDS_IN, RnW_IN, A_IN, FC_IN, D_IN,
        output D_OUT, D_OE, nDTACK_OE, nBERR_OE
    );
endinterface

// File: rtl/m68k_bus_target.sv
// Responder for the 68000 asynchronous bus.
// It decodes an address window, hands each hit to a single-word backend
// and terminates the cycle with DTACK, or with BERR on error or timeout.
// All bus strobes and the 7 MHz bus clock are sampled through 2-flop
// synchronizers.
module m68k_bus_target #(
    parameter logic [22:0] BASE_ADDR      = 23'h740000,
    parameter logic [22:0] ADDR_MASK      = 23'h7F8000,
    parameter int          WAIT_STATES    = 0,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                    sys_clk,
    input  logic                    nRESET,
    m68k_bus_target_if.slave        bus,
    output logic                    be_req,
    output logic                    be_write,
    output logic [22:0]             be_addr,
    output logic [1:0]              be_be,
    output logic [15:0]             be_wdata,
    input  logic                    be_ack,
    input  logic                    be_err,
    input  logic [15:0]             be_rdata,
    output logic                    busy
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_IGNORE  = 3'd1;
    localparam logic [2:0] ST_WAIT_DS = 3'd2;
    localparam logic [2:0] ST_BACKEND = 3'd3;
    localparam logic [2:0] ST_WAIT    = 3'd4;
    localparam logic [2:0] ST_DTACK   = 3'd5;
    localparam logic [2:0] ST_BERR    = 3'd6;

    // Limits widened by one bit so the incremented counters never wrap
    // before the comparison.
    localparam logic [8:0] TMO_LIMIT = 9'(TIMEOUT_CYCLES);
    localparam logic [4:0] WS_LIMIT  = 5'(WAIT_STATES);

    // Synchronizer bit positions.
    localparam int SY_AS  = 0;
    localparam int SY_UDS = 1;
    localparam int SY_LDS = 2;
    localparam int SY_RNW = 3;
    localparam int SY_C7M = 4;

    logic [4:0]  pin_vec;
    logic [4:0]  sync1_reg;
    logic [4:0]  sync2_reg;
    logic        as_prev_reg;
    logic        c7m_prev_reg;

    logic        as_synced;
    logic        uds_synced;
    logic        lds_synced;
    logic        rnw_synced;
    logic        c7m_synced;
    logic        as_fall;
    logic        c7m_fall;
    logic        addr_hit;

    logic [2:0]  state_reg,     state_next;
    logic        be_req_reg,    be_req_next;
    logic        be_write_reg,  be_write_next;
    logic [22:0] be_addr_reg,   be_addr_next;
    logic [1:0]  be_be_reg,     be_be_next;
    logic [15:0] be_wdata_reg,  be_wdata_next;
    logic [15:0] d_out_reg,     d_out_next;
    logic        d_oe_reg,      d_oe_next;
    logic        dtack_reg,     dtack_next;
    logic        berr_reg,      berr_next;
    logic [7:0]  tmo_cnt_reg,   tmo_cnt_next;
    logic [3:0]  ws_cnt_reg,    ws_cnt_next;

    logic [8:0]  tmo_inc;
    logic [4:0]  ws_inc;

    assign pin_vec = {bus.CLK_7M, bus.RnW_IN, bus.nLDS_IN, bus.nUDS_IN, bus.nAS_IN};

    // Two-stage synchronizers plus the edge-detect history. Everything
    // resets to 0 so a strobe that is already low when reset releases
    // never looks like a fresh falling edge.
    always_ff @(posedge sys_clk) begin
        if (!nRESET) begin
            sync1_reg    <= '0;
            sync2_reg    <= '0;
            as_prev_reg  <= 1'b0;
            c7m_prev_reg <= 1'b0;
        end else begin
            sync1_reg    <= pin_vec;
            sync2_reg    <= sync1_reg;
            as_prev_reg  <= sync2_reg[SY_AS];
            c7m_prev_reg <= sync2_reg[SY_C7M];
        end
    end

    assign as_synced  = sync2_reg[SY_AS];
    assign uds_synced = sync2_reg[SY_UDS];
    assign lds_synced = sync2_reg[SY_LDS];
    assign rnw_synced = sync2_reg[SY_RNW];
    assign c7m_synced = sync2_reg[SY_C7M];

    assign as_fall  = as_prev_reg  & ~as_synced;
    assign c7m_fall = c7m_prev_reg & ~c7m_synced;

    // CPU space (interrupt acknowledge etc.) is never claimed, whatever
    // address it carries.
    assign addr_hit = ((bus.A_IN & ADDR_MASK) == (BASE_ADDR & ADDR_MASK))
                      && (bus.FC_IN != 3'b111);

    assign tmo_inc = {1'b0, tmo_cnt_reg} + 9'd1;
    assign ws_inc  = {1'b0, ws_cnt_reg} + 5'd1;

    // Next-state and output decisions for the bus cycle.
    always_comb begin
        state_next    = state_reg;
        be_req_next   = be_req_reg;
        be_write_next = be_write_reg;
        be_addr_next  = be_addr_reg;
        be_be_next    = be_be_reg;
        be_wdata_next = be_wdata_reg;
        d_out_next    = d_out_reg;
        d_oe_next     = d_oe_reg;
        dtack_next    = dtack_reg;
        berr_next     = berr_reg;
        tmo_cnt_next  = tmo_cnt_reg;
        ws_cnt_next   = ws_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (as_fall) begin
                    be_addr_next  = bus.A_IN;
                    be_write_next = ~rnw_synced;
                    state_next    = addr_hit ? ST_WAIT_DS : ST_IGNORE;
                end
            end

            ST_IGNORE: begin
                if (as_synced) begin
                    state_next = ST_IDLE;
                end
            end

            ST_WAIT_DS: begin
                // A data strobe takes priority over a simultaneous nAS
                // negation so a seen strobe is always serviced.
                if (!uds_synced || !lds_synced) begin
                    be_be_next = ~{uds_synced, lds_synced};
                    if (be_write_reg) begin
                        be_wdata_next = bus.D_IN;
                    end
                    be_req_next  = 1'b1;
                    tmo_cnt_next = 8'd0;
                    state_next   = ST_BACKEND;
                end else if (as_synced) begin
                    state_next = ST_IDLE;
                end
            end

            ST_BACKEND: begin
                tmo_cnt_next = tmo_inc[7:0];
                // The backend transaction always completes; if the master
                // has already gone away, nothing is driven afterwards and
                // the following state drops straight back to IDLE.
                if (be_ack) begin
                    be_req_next = 1'b0;
                    if (be_err) begin
                        berr_next  = ~as_synced;
                        state_next = ST_BERR;
                    end else begin
                        if (!be_write_reg) begin
                            d_out_next = be_rdata;
                            d_oe_next  = ~as_synced;
                        end
                        ws_cnt_next = 4'd0;
                        state_next  = ST_WAIT;
                    end
                end else if (tmo_inc == TMO_LIMIT) begin
                    be_req_next = 1'b0;
                    berr_next   = ~as_synced;
                    state_next  = ST_BERR;
                end
            end

            ST_WAIT: begin
                if (as_synced) begin
                    d_oe_next  = 1'b0;
                    state_next = ST_IDLE;
                end else if (WS_LIMIT == 5'd0) begin
                    dtack_next = 1'b1;
                    state_next = ST_DTACK;
                end else if (c7m_fall) begin
                    if (ws_inc == WS_LIMIT) begin
                        dtack_next = 1'b1;
                        state_next = ST_DTACK;
                    end else begin
                        ws_cnt_next = ws_inc[3:0];
                    end
                end
            end

            ST_DTACK: begin
                if (as_synced) begin
                    dtack_next = 1'b0;
                    d_oe_next  = 1'b0;
                    state_next = ST_IDLE;
                end
            end

            ST_BERR: begin
                d_oe_next = 1'b0;
                if (as_synced) begin
                    berr_next  = 1'b0;
                    state_next = ST_IDLE;
                end
            end

            default: begin
                be_req_next = 1'b0;
                d_oe_next   = 1'b0;
                dtack_next  = 1'b0;
                berr_next   = 1'b0;
                state_next  = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset releases every bus driver at once.
    always_ff @(posedge sys_clk) begin
        if (!nRESET) begin
            state_reg    <= ST_IDLE;
            be_req_reg   <= 1'b0;
            be_write_reg <= 1'b0;
            be_addr_reg  <= '0;
            be_be_reg    <= '0;
            be_wdata_reg <= '0;
            d_out_reg    <= '0;
            d_oe_reg     <= 1'b0;
            dtack_reg    <= 1'b0;
            berr_reg     <= 1'b0;
            tmo_cnt_reg  <= '0;
            ws_cnt_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            be_req_reg   <= be_req_next;
            be_write_reg <= be_write_next;
            be_addr_reg  <= be_addr_next;
            be_be_reg    <= be_be_next;
            be_wdata_reg <= be_wdata_next;
            d_out_reg    <= d_out_next;
            d_oe_reg     <= d_oe_next;
            dtack_reg    <= dtack_next;
            berr_reg     <= berr_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            ws_cnt_reg   <= ws_cnt_next;
        end
    end

    assign be_req        = be_req_reg;
    assign be_write      = be_write_reg;
    assign be_addr       = be_addr_reg;
    assign be_be         = be_be_reg;
    assign be_wdata      = be_wdata_reg;
    assign busy          = (state_reg != ST_IDLE);

    assign bus.D_OUT     = d_out_reg;
    assign bus.D_OE      = d_oe_reg;
    assign bus.nDTACK_OE = dtack_reg;
    assign bus.nBERR_OE  = berr_reg;

endmodule

// File: tb/tb_m68k_bus_target.sv
// Bench for m68k_bus_target: a per-cycle vector table for the basic
// read/write/miss/error cycles, then directed sequences for timeout,
// wait states and reset in the middle of a cycle.
module tb_m68k_bus_target;

    localparam logic [22:0] A_RD   = 23'h740008;  // byte 0xE80010
    localparam logic [22:0] A_WR   = 23'h740010;  // byte 0xE80021
    localparam logic [22:0] A_MISS = 23'h5FF000;  // byte 0xBFE001

    logic        sys_clk;
    logic        nRESET;

    logic        a_be_req, a_be_write, a_be_ack, a_be_err, a_busy;
    logic [22:0] a_be_addr;
    logic [1:0]  a_be_be;
    logic [15:0] a_be_wdata, a_be_rdata;

    logic        b_be_req, b_be_write, b_be_ack, b_be_err, b_busy;
    logic [22:0] b_be_addr;
    logic [1:0]  b_be_be;
    logic [15:0] b_be_wdata, b_be_rdata;

    int checks;
    int failures;

    m68k_bus_target_if bus_a ();
    m68k_bus_target_if bus_b ();

    m68k_bus_target #(
        .WAIT_STATES    (0),
        .TIMEOUT_CYCLES (255)
    ) dut_a (
        .sys_clk  (sys_clk),
        .nRESET   (nRESET),
        .bus      (bus_a),
        .be_req   (a_be_req),
        .be_write (a_be_write),
        .be_addr  (a_be_addr),
        .be_be    (a_be_be),
        .be_wdata (a_be_wdata),
        .be_ack   (a_be_ack),
        .be_err   (a_be_err),
        .be_rdata (a_be_rdata),
        .busy     (a_busy)
    );

    m68k_bus_target #(
        .WAIT_STATES    (2),
        .TIMEOUT_CYCLES (255)
    ) dut_b (
        .sys_clk  (sys_clk),
        .nRESET   (nRESET),
        .bus      (bus_b),
        .be_req   (b_be_req),
        .be_write (b_be_write),
        .be_addr  (b_be_addr),
        .be_be    (b_be_be),
        .be_wdata (b_be_wdata),
        .be_ack   (b_be_ack),
        .be_err   (b_be_err),
        .be_rdata (b_be_rdata),
        .busy     (b_busy)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // One record per sys_clk edge: pin/backend inputs applied before the
    // edge, expected outputs sampled 1 ns after it.
    typedef struct {
        logic        nreset;
        logic        nas;
        logic [1:0]  nds;     // {nUDS, nLDS}
        logic        rnw;
        logic [22:0] a;
        logic [2:0]  fc;
        logic [15:0] d;
        logic        ack;
        logic        err;
        logic [15:0] rdata;
        logic [4:0]  flags;   // {be_req, D_OE, nDTACK_OE, nBERR_OE, busy}
        logic [15:0] dout;
        logic        chk_be;
        logic [41:0] exp_be;  // {be_write, be_be, be_addr, be_wdata}
    } vec_t;

    vec_t        vecs[$];
    logic        pend_chk;
    logic [41:0] pend_be;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [4:0] flags_a();
        return {a_be_req, bus_a.D_OE, bus_a.nDTACK_OE, bus_a.nBERR_OE, a_busy};
    endfunction

    function automatic logic [4:0] flags_b();
        return {b_be_req, bus_b.D_OE, bus_b.nDTACK_OE, bus_b.nBERR_OE, b_busy};
    endfunction

    task automatic expect_be(input logic w, input logic [1:0] be, input logic [22:0] addr,
                             input logic [15:0] wdata);
        pend_chk = 1'b1;
        pend_be  = {w, be, addr, wdata};
    endtask

    task automatic add_vec(input logic nrst, input logic nas, input logic [1:0] nds,
                           input logic rnw, input logic [22:0] a, input logic [2:0] fc,
                           input logic [15:0] d, input logic ack, input logic err,
                           input logic [15:0] rdata, input logic [4:0] flags,
                           input logic [15:0] dout, input int n);
        vec_t v;
        v.nreset = nrst;  v.nas = nas;  v.nds = nds;  v.rnw = rnw;
        v.a = a;  v.fc = fc;  v.d = d;
        v.ack = ack;  v.err = err;  v.rdata = rdata;
        v.flags = flags;  v.dout = dout;
        v.chk_be = pend_chk;  v.exp_be = pend_be;
        for (int k = 0; k < n; k++) vecs.push_back(v);
        pend_chk = 1'b0;
    endtask

    task automatic drive_a(input logic nas, input logic [1:0] nds, input logic rnw,
                           input logic [22:0] a, input logic [2:0] fc);
        bus_a.nAS_IN  = nas;
        bus_a.nUDS_IN = nds[1];
        bus_a.nLDS_IN = nds[0];
        bus_a.RnW_IN  = rnw;
        bus_a.A_IN    = a;
        bus_a.FC_IN   = fc;
    endtask

    task automatic drive_b(input logic nas, input logic [1:0] nds, input logic rnw,
                           input logic [22:0] a, input logic [2:0] fc);
        bus_b.nAS_IN  = nas;
        bus_b.nUDS_IN = nds[1];
        bus_b.nLDS_IN = nds[0];
        bus_b.RnW_IN  = rnw;
        bus_b.A_IN    = a;
        bus_b.FC_IN   = fc;
    endtask

    // Hard stop in case something never returns.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        pend_chk = 1'b0;
        pend_be  = '0;

        nRESET     = 1'b0;
        a_be_ack   = 1'b0;  a_be_err = 1'b0;  a_be_rdata = 16'h0000;
        b_be_ack   = 1'b0;  b_be_err = 1'b0;  b_be_rdata = 16'h0000;
        bus_a.CLK_7M = 1'b1;  bus_a.D_IN = 16'h0000;
        bus_b.CLK_7M = 1'b1;  bus_b.D_IN = 16'h0000;
        drive_a(1'b1, 2'b11, 1'b1, 23'h0, 3'd0);
        drive_b(1'b1, 2'b11, 1'b1, 23'h0, 3'd0);

        // ---------------- vector table ----------------
        // reset, then idle until the edge detector history is primed
        add_vec(0, 1, 2'b11, 1, 23'h0, 3'd0, 16'h0, 0, 0, 16'h0, 5'b00000, 16'h0000, 2);
        add_vec(1, 1, 2'b11, 1, 23'h0, 3'd0, 16'h0, 0, 0, 16'h0, 5'b00000, 16'h0000, 3);
        // read hit, both strobes, ack 3 cycles after be_req with 0xBEEF
        add_vec(1, 0, 2'b00, 1, A_RD, 3'd5, 16'h0, 0, 0, 16'h0,    5'b00000, 16'h0000, 2);
        add_vec(1, 0, 2'b00, 1, A_RD, 3'd5, 16'h0, 0, 0, 16'h0,    5'b00001, 16'h0000, 1);
        add_vec(1, 0, 2'b00, 1, A_RD, 3'd5, 16'h0, 0, 0, 16'h0,    5'b10001, 16'h0000, 3);
        add_vec(1, 0, 2'b00, 1, A_RD, 3'd5, 16'h0, 1, 0, 16'hBEEF, 5'b01001, 16'hBEEF, 1);
        add_vec(1, 0, 2'b00, 1, A_RD, 3'd5, 16'h0, 0, 0, 16'h0,    5'b01101, 16'hBEEF, 2);
        add_vec(1, 1, 2'b11, 1, A_RD, 3'd5, 16'h0, 0, 0, 16'h0,    5'b01101, 16'hBEEF, 2);
        expect_be(1'b0, 2'b11, A_RD, 16'h0000);
        add_vec(1, 1, 2'b11, 1, A_RD, 3'd5, 16'h0, 0, 0, 16'h0,    5'b00000, 16'hBEEF, 2);
        // write, lower strobe only, 0x00A5; rdata on ack must not be latched
        add_vec(1, 0, 2'b11, 0, A_WR, 3'd5, 16'h00A5, 0, 0, 16'h0,    5'b00000, 16'hBEEF, 1);
        add_vec(1, 0, 2'b10, 0, A_WR, 3'd5, 16'h00A5, 0, 0, 16'h0,    5'b00000, 16'hBEEF, 1);
        add_vec(1, 0, 2'b10, 0, A_WR, 3'd5, 16'h00A5, 0, 0, 16'h0,    5'b00001, 16'hBEEF, 1);
        add_vec(1, 0, 2'b10, 0, A_WR, 3'd5, 16'h00A5, 0, 0, 16'h0,    5'b10001, 16'hBEEF, 1);
        add_vec(1, 0, 2'b10, 0, A_WR, 3'd5, 16'h00A5, 1, 0, 16'hFFFF, 5'b00001, 16'hBEEF, 1);
        add_vec(1, 0, 2'b10, 0, A_WR, 3'd5, 16'h00A5, 0, 0, 16'h0,    5'b00101, 16'hBEEF, 2);
        add_vec(1, 1, 2'b11, 0, A_WR, 3'd5, 16'h00A5, 0, 0, 16'h0,    5'b00101, 16'hBEEF, 2);
        expect_be(1'b1, 2'b01, A_WR, 16'h00A5);
        add_vec(1, 1, 2'b11, 0, A_WR, 3'd5, 16'h00A5, 0, 0, 16'h0,    5'b00000, 16'hBEEF, 2);
        // miss outside the window: busy but nothing driven
        add_vec(1, 0, 2'b00, 1, A_MISS, 3'd5, 16'h0, 0, 0, 16'h0, 5'b00000, 16'hBEEF, 2);
        add_vec(1, 0, 2'b00, 1, A_MISS, 3'd5, 16'h0, 0, 0, 16'h0, 5'b00001, 16'hBEEF, 4);
        add_vec(1, 1, 2'b11, 1, A_MISS, 3'd5, 16'h0, 0, 0, 16'h0, 5'b00001, 16'hBEEF, 2);
        add_vec(1, 1, 2'b11, 1, A_MISS, 3'd5, 16'h0, 0, 0, 16'h0, 5'b00000, 16'hBEEF, 2);
        // hit address in CPU space: ignored
        add_vec(1, 0, 2'b00, 1, A_RD, 3'd7, 16'h0, 0, 0, 16'h0, 5'b00000, 16'hBEEF, 2);
        add_vec(1, 0, 2'b00, 1, A_RD, 3'd7, 16'h0, 0, 0, 16'h0, 5'b00001, 16'hBEEF, 4);
        add_vec(1, 1, 2'b11, 1, A_RD, 3'd7, 16'h0, 0, 0, 16'h0, 5'b00001, 16'hBEEF, 2);
        add_vec(1, 1, 2'b11, 1, A_RD, 3'd7, 16'h0, 0, 0, 16'h0, 5'b00000, 16'hBEEF, 2);
        // backend error ends the read with BERR, no data driven
        add_vec(1, 0, 2'b00, 1, A_RD, 3'd5, 16'h0, 0, 0, 16'h0,    5'b00000, 16'hBEEF, 2);
        add_vec(1, 0, 2'b00, 1, A_RD, 3'd5, 16'h0, 0, 0, 16'h0,    5'b00001, 16'hBEEF, 1);
        add_vec(1, 0, 2'b00, 1, A_RD, 3'd5, 16'h0, 0, 0, 16'h0,    5'b10001, 16'hBEEF, 1);
        add_vec(1, 0, 2'b00, 1, A_RD, 3'd5, 16'h0, 1, 1, 16'h1111, 5'b00011, 16'hBEEF, 1);
        add_vec(1, 0, 2'b00, 1, A_RD, 3'd5, 16'h0, 0, 0, 16'h0,    5'b00011, 16'hBEEF, 1);
        add_vec(1, 1, 2'b11, 1, A_RD, 3'd5, 16'h0, 0, 0, 16'h0,    5'b00011, 16'hBEEF, 2);
        add_vec(1, 1, 2'b11, 1, A_RD, 3'd5, 16'h0, 0, 0, 16'h0,    5'b00000, 16'hBEEF, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            nRESET      = vecs[i].nreset;
            drive_a(vecs[i].nas, vecs[i].nds, vecs[i].rnw, vecs[i].a, vecs[i].fc);
            bus_a.D_IN  = vecs[i].d;
            a_be_ack    = vecs[i].ack;
            a_be_err    = vecs[i].err;
            a_be_rdata  = vecs[i].rdata;
            tick();
            $display("vec %0d: flags=%b dout=%h", i, flags_a(), bus_a.D_OUT);
            check($sformatf("vec%0d", i), 64'({flags_a(), bus_a.D_OUT}),
                  64'({vecs[i].flags, vecs[i].dout}));
            if (vecs[i].chk_be) begin
                check($sformatf("vec%0d_be", i),
                      64'({a_be_write, a_be_be, a_be_addr, a_be_wdata}), 64'(vecs[i].exp_be));
            end
        end
        a_be_ack = 1'b0;
        a_be_err = 1'b0;

        // ---------------- timeout: no ack at all ----------------
        drive_a(1'b0, 2'b00, 1'b1, A_RD, 3'd5);
        ticks(3);
        check("tmo_req_pre", 64'(a_be_req), 64'd0);
        tick();
        check("tmo_req_rise", 64'(a_be_req), 64'd1);
        ticks(254);
        check("tmo_early", 64'(flags_a()), 64'(5'b10001));
        tick();
        $display("timeout: flags=%b after 255 cycles", flags_a());
        check("tmo_berr", 64'(flags_a()), 64'(5'b00011));
        a_be_ack   = 1'b1;
        a_be_rdata = 16'h1234;
        tick();
        a_be_ack   = 1'b0;
        tick();
        check("tmo_late_ack", 64'({flags_a(), bus_a.D_OUT}), 64'({5'b00011, 16'hBEEF}));
        drive_a(1'b1, 2'b11, 1'b1, A_RD, 3'd5);
        ticks(2);
        check("tmo_hold", 64'(bus_a.nBERR_OE), 64'd1);
        tick();
        check("tmo_release", 64'(flags_a()), 64'(5'b00000));

        // ---------------- wait states (instance with 2) ----------------
        drive_b(1'b0, 2'b00, 1'b1, A_RD, 3'd5);
        ticks(4);
        check("ws_req", 64'(b_be_req), 64'd1);
        b_be_ack   = 1'b1;
        b_be_rdata = 16'h5A5A;
        tick();
        b_be_ack   = 1'b0;
        check("ws_latch", 64'({flags_b(), bus_b.D_OUT}), 64'({5'b01001, 16'h5A5A}));
        ticks(3);
        check("ws_no_strobe", 64'(bus_b.nDTACK_OE), 64'd0);
        bus_b.CLK_7M = 1'b0;
        ticks(3);
        check("ws_first_strobe", 64'(bus_b.nDTACK_OE), 64'd0);
        bus_b.CLK_7M = 1'b1;
        ticks(3);
        bus_b.CLK_7M = 1'b0;
        ticks(2);
        check("ws_pre", 64'(bus_b.nDTACK_OE), 64'd0);
        tick();
        $display("wait states: flags=%b after 2nd strobe", flags_b());
        check("ws_dtack", 64'({flags_b(), bus_b.D_OUT}), 64'({5'b01101, 16'h5A5A}));
        bus_b.CLK_7M = 1'b1;
        drive_b(1'b1, 2'b11, 1'b1, A_RD, 3'd5);
        ticks(3);
        check("ws_release", 64'(flags_b()), 64'(5'b00000));

        // ---------------- reset during DTACK ----------------
        drive_a(1'b0, 2'b00, 1'b1, A_RD, 3'd5);
        ticks(4);
        a_be_ack   = 1'b1;
        a_be_rdata = 16'hC0DE;
        tick();
        a_be_ack   = 1'b0;
        tick();
        check("rst_pre_dtack", 64'({flags_a(), bus_a.D_OUT}), 64'({5'b01101, 16'hC0DE}));
        nRESET = 1'b0;
        tick();
        check("rst_mid", 64'({flags_a(), bus_a.D_OUT, a_be_addr, a_be_be}), 64'd0);
        nRESET = 1'b1;
        ticks(8);
        check("rst_no_reterm", 64'(flags_a()), 64'(5'b00000));
        drive_a(1'b1, 2'b11, 1'b1, A_RD, 3'd5);
        ticks(4);
        drive_a(1'b0, 2'b00, 1'b1, A_RD, 3'd5);
        ticks(4);
        check("rst_next_req", 64'(a_be_req), 64'd1);
        a_be_ack   = 1'b1;
        a_be_rdata = 16'h1357;
        tick();
        a_be_ack   = 1'b0;
        tick();
        check("rst_next_dtack", 64'({flags_a(), bus_a.D_OUT}), 64'({5'b01101, 16'h1357}));
        drive_a(1'b1, 2'b11, 1'b1, A_RD, 3'd5);
        ticks(3);
        check("rst_next_release", 64'(flags_a()), 64'(5'b00000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
